// File: rtl/aes_loader_pkg.sv
// Shared types and sizing helpers for the AES word loader.
// Optional feature macro used elsewhere in this slice: AES_LOADER_BLKCNT_EN.
package aes_loader_pkg;

  typedef enum logic [1:0] {COLLECT, FIRE, WAIT, DONE} state_t;

  localparam int DEF_DATA_W = 32;
  localparam int NW         = 128 / DEF_DATA_W;
  localparam int CNT_W      = $clog2(NW);

  function automatic int words_per_block(input int dw);
    return 128 / dw;
  endfunction

endpackage

// File: rtl/aes_word_loader_if.sv
// Valid/ready word stream feeding the AES loader; is_key selects the key or plaintext path.
interface aes_word_loader_if #(parameter int DATA_W = 32);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              is_key;

  modport master (output valid, output data, output is_key, input ready);
  modport slave  (input valid, input data, input is_key, output ready);
endinterface

// File: rtl/aes_word_shifter.sv
// Shift-in assembly register: first word lands in the top bits after NW shifts.
module aes_word_shifter #(
  parameter  int DATA_W = 32,
  parameter  int NW     = 4,
  localparam int CW     = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [127:0]      value,
  output logic [CW-1:0]     cnt,
  output logic              wrap
);

  assign wrap = shift_en && (cnt == CW'(NW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      value <= {value[127-DATA_W:0], din};
      cnt   <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aes_word_loader.sv
// Assembles key/plaintext words, strobes the AES core and flags when its ciphertext is valid.
// Optional block counter output enabled by AES_LOADER_BLKCNT_EN.
module aes_word_loader
  import aes_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CT_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_word_loader_if.slave   s,
  output logic               aes_en,
  output logic [127:0]       aes_plaintext,
  output logic [127:0]       aes_key,
  output logic               key_vld,
  output logic               busy,
  output logic               ct_valid
`ifdef AES_LOADER_BLKCNT_EN
  ,
  output logic [31:0]        blk_cnt
`endif
);

  localparam int WORDS  = words_per_block(DATA_W);
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAIT_W = $clog2(CT_LAT);

  state_t              state, state_n;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WCNT_W-1:0]   key_cnt, pt_cnt;
  logic                key_wrap, pt_wrap;
  logic                key_acc, pt_acc;

  // Plaintext stalls until a full key is held; key words are always taken while collecting.
  assign s.ready = (state == COLLECT) && (s.is_key || key_vld);
  assign key_acc = s.valid && s.ready && s.is_key;
  assign pt_acc  = s.valid && s.ready && !s.is_key;

  aes_word_shifter #(.DATA_W(DATA_W), .NW(WORDS)) u_key (
    .clk(clk), .rst_n(rst_n), .shift_en(key_acc), .din(s.data),
    .value(aes_key), .cnt(key_cnt), .wrap(key_wrap)
  );

  aes_word_shifter #(.DATA_W(DATA_W), .NW(WORDS)) u_pt (
    .clk(clk), .rst_n(rst_n), .shift_en(pt_acc), .din(s.data),
    .value(aes_plaintext), .cnt(pt_cnt), .wrap(pt_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      wait_cnt <= '0;
      key_vld  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == FIRE)
        wait_cnt <= WAIT_W'(CT_LAT - 2);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      // A new key load invalidates the old key on its first word; NW >= 2 keeps clear/set apart.
      if (key_acc && key_cnt == '0)
        key_vld <= 1'b0;
      if (key_wrap)
        key_vld <= 1'b1;
    end
  end

  // WAIT spans CT_LAT-1 cycles so DONE (ct_valid) lands exactly CT_LAT cycles after FIRE (aes_en).
  always_comb begin
    state_n  = state;
    aes_en   = 1'b0;
    busy     = 1'b0;
    ct_valid = 1'b0;
    case (state)
      COLLECT: if (pt_wrap) state_n = FIRE;
      FIRE: begin
        aes_en  = 1'b1;
        busy    = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wait_cnt == '0) state_n = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        ct_valid = 1'b1;
        state_n  = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

`ifdef AES_LOADER_BLKCNT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blk_cnt_q <= '0;
    else if (ct_valid)
      blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed bench for aes_word_loader using the FIPS-197 C.1 key/plaintext words.
module tb_aes_word_loader;

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2  = 128'hccddeeff8899aabb4455667700112233;
  localparam logic [127:0] NKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst_n, rst3_n;
  always #5 clk = ~clk;

  aes_word_loader_if #(.DATA_W(32)) s ();
  aes_word_loader_if #(.DATA_W(32)) s3 ();
  assign s3.valid  = s.valid;
  assign s3.data   = s.data;
  assign s3.is_key = s.is_key;

  logic         aes_en, key_vld, busy, ct_valid;
  logic [127:0] aes_pt, aes_key;
  logic         aes_en3, key_vld3, busy3, ct_valid3;
  logic [127:0] aes_pt3, aes_key3;
`ifdef AES_LOADER_BLKCNT_EN
  logic [31:0]  blk_cnt, blk_cnt3;
`endif

  aes_word_loader #(.DATA_W(32), .CT_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .aes_en(aes_en), .aes_plaintext(aes_pt),
    .aes_key(aes_key), .key_vld(key_vld), .busy(busy), .ct_valid(ct_valid)
`ifdef AES_LOADER_BLKCNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  aes_word_loader #(.DATA_W(32), .CT_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .s(s3), .aes_en(aes_en3), .aes_plaintext(aes_pt3),
    .aes_key(aes_key3), .key_vld(key_vld3), .busy(busy3), .ct_valid(ct_valid3)
`ifdef AES_LOADER_BLKCNT_EN
    , .blk_cnt(blk_cnt3)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int ct3_n = 0;
  int           en_cyc[$];
  int           ct_cyc[$];
  logic [127:0] en_key[$];
  logic [127:0] en_pt[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (aes_en) begin
      en_cyc.push_back(cyc);
      en_key.push_back(aes_key);
      en_pt.push_back(aes_pt);
    end
    if (ct_valid) ct_cyc.push_back(cyc);
    if (busy && s.ready) viol++;
    if (ct_valid3) ct3_n++;
  end

  function automatic void split(input logic [127:0] v, output logic [31:0] w[$]);
    w = {};
    for (int i = 3; i >= 0; i--) w.push_back(v[i*32 +: 32]);
  endfunction

  // Entered and left at posedge+1; each word is counted when valid && ready at the edge.
  task automatic stream(input logic k, input logic [31:0] w[$], input bit stall);
    int  i = 0;
    int  n = 0;
    logic acc;
    s.is_key = k;
    while (i < w.size() && n < 400) begin
      s.data  = w[i];
      s.valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = s.valid && s.ready;
      @(posedge clk); #1;
      if (acc) i++;
      n++;
    end
    s.valid = 1'b0;
    checks++;
    if (i != w.size()) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d words, required %0d", i, w.size());
    end
  endtask

  task automatic do_reset();
    s.valid = 1'b0; s.is_key = 1'b0; s.data = '0;
    rst_n = 1'b0; rst3_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({aes_en, busy, ct_valid, key_vld, s.ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {aes_en, busy, ct_valid, key_vld, s.ready});
    end
    checks++;
    if (aes_key !== '0 || aes_pt !== '0) begin
      errors++;
      $display("FAIL reset_data: key %h pt %h required 0", aes_key, aes_pt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pt_before_key();
    logic [31:0] w[$];
    s.valid = 1'b1; s.is_key = 1'b0; s.data = PT[127:96];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (s.ready !== 1'b0 || aes_en !== 1'b0) begin
        errors++;
        $display("FAIL t1_stall: ready %b aes_en %b required 0 0", s.ready, aes_en);
      end
      @(posedge clk); #1;
    end
    split(KEY, w);
    stream(1'b1, w, 1'b0);
    @(negedge clk);
    checks++;
    if (key_vld !== 1'b1 || aes_key !== KEY) begin
      errors++;
      $display("FAIL t1_key: key_vld %b key %h required 1 %h", key_vld, aes_key, KEY);
    end
    @(posedge clk); #1;
    split(PT, w);
    stream(1'b0, w, 1'b0);
    @(negedge clk);
    checks++;
    if (aes_en !== 1'b1 || busy !== 1'b1 || aes_pt !== PT || aes_key !== KEY) begin
      errors++;
      $display("FAIL t1_fire: aes_en %b busy %b pt %h key %h", aes_en, busy, aes_pt, aes_key);
    end
    @(negedge clk);
    checks++;
    if (ct_valid !== 1'b0 || aes_en !== 1'b0) begin
      errors++;
      $display("FAIL t1_k1: ct_valid %b aes_en %b required 0 0", ct_valid, aes_en);
    end
    @(negedge clk);
    checks++;
    if (ct_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_ct: ct_valid %b busy %b required 1 1", ct_valid, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    logic [31:0] a[$];
    int eb = en_cyc.size();
    int cb = ct_cyc.size();
    int vb = viol;
    split(PT, w);
    split(PT2, a); w = {w, a};
    split(128'h0, a); w = {w, a};
    stream(1'b0, w, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (en_cyc.size() - eb != 3 || ct_cyc.size() - cb != 3) begin
      errors++;
      $display("FAIL t2_count: aes_en %0d ct_valid %0d required 3 3", en_cyc.size() - eb, ct_cyc.size() - cb);
    end else begin
      checks++;
      if (en_cyc[eb+1] - en_cyc[eb] != 7 || en_cyc[eb+2] - en_cyc[eb+1] != 7) begin
        errors++;
        $display("FAIL t2_spacing: got %0d %0d required 7 7",
                 en_cyc[eb+1] - en_cyc[eb], en_cyc[eb+2] - en_cyc[eb+1]);
      end
      checks++;
      if (ct_cyc[cb+2] - en_cyc[eb+2] != 2) begin
        errors++;
        $display("FAIL t2_latency: got %0d required 2", ct_cyc[cb+2] - en_cyc[eb+2]);
      end
      checks++;
      if (en_pt[eb] !== PT || en_pt[eb+1] !== PT2 || en_pt[eb+2] !== 128'h0) begin
        errors++;
        $display("FAIL t2_blocks: got %h %h %h", en_pt[eb], en_pt[eb+1], en_pt[eb+2]);
      end
    end
    checks++;
    if (viol != vb) begin
      errors++;
      $display("FAIL t2_ready_busy: %0d busy cycles with s_ready, required 0", viol - vb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_key_reload();
    logic [31:0] p[$];
    logic [31:0] k[$];
    logic [31:0] one[$];
    int eb = en_cyc.size();
    split(PT, p);
    split(NKEY, k);
    one = {p[0], p[1]};
    stream(1'b0, one, 1'b0);
    one = {k[0]};
    stream(1'b1, one, 1'b0);
    s.valid = 1'b1; s.is_key = 1'b0; s.data = p[2];
    @(negedge clk);
    checks++;
    if (key_vld !== 1'b0 || s.ready !== 1'b0) begin
      errors++;
      $display("FAIL t3_drop: key_vld %b pt_ready %b required 0 0", key_vld, s.ready);
    end
    @(posedge clk); #1;
    s.valid = 1'b0;
    one = {k[1], k[2]};
    stream(1'b1, one, 1'b0);
    @(negedge clk);
    checks++;
    if (key_vld !== 1'b0) begin
      errors++;
      $display("FAIL t3_partial: key_vld %b required 0", key_vld);
    end
    @(posedge clk); #1;
    one = {k[3]};
    stream(1'b1, one, 1'b0);
    @(negedge clk);
    checks++;
    if (key_vld !== 1'b1 || aes_en !== 1'b0) begin
      errors++;
      $display("FAIL t3_rise: key_vld %b aes_en %b required 1 0", key_vld, aes_en);
    end
    @(posedge clk); #1;
    one = {p[2], p[3]};
    stream(1'b0, one, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (en_cyc.size() - eb != 1) begin
      errors++;
      $display("FAIL t3_fire: %0d aes_en pulses required 1", en_cyc.size() - eb);
    end else begin
      checks++;
      if (en_key[eb] !== NKEY || en_pt[eb] !== PT) begin
        errors++;
        $display("FAIL t3_values: key %h pt %h required %h %h", en_key[eb], en_pt[eb], NKEY, PT);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wait();
    logic [31:0] w[$];
    int cb;
    do_reset();
    split(KEY, w);
    stream(1'b1, w, 1'b0);
    split(PT, w);
    stream(1'b0, w, 1'b0);
    @(negedge clk);
    checks++;
    if (aes_en3 !== 1'b1) begin
      errors++;
      $display("FAIL t4_fire: aes_en %b required 1", aes_en3);
    end
    cb = ct3_n;
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    checks++;
    if ({aes_en3, busy3, ct_valid3, key_vld3, s3.ready} !== 5'b0 || aes_key3 !== '0 || aes_pt3 !== '0) begin
      errors++;
      $display("FAIL t4_abort: ctrl %b key %h pt %h required 0",
               {aes_en3, busy3, ct_valid3, key_vld3, s3.ready}, aes_key3, aes_pt3);
    end
    repeat (2) @(negedge clk);
    rst3_n = 1'b1;
    @(posedge clk); #1;
    s.is_key = 1'b0; s.data = PT[127:96];
    @(negedge clk);
    checks++;
    if (key_vld3 !== 1'b0 || s3.ready !== 1'b0 || ct3_n != cb) begin
      errors++;
      $display("FAIL t4_after: key_vld %b ready %b ct_valid pulses %0d required 0 0 0",
               key_vld3, s3.ready, ct3_n - cb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [31:0] w[$];
    int eb;
    do_reset();
    eb = en_cyc.size();
    split(KEY, w);
    stream(1'b1, w, 1'b1);
    split(PT, w);
    stream(1'b0, w, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (en_cyc.size() - eb != 1) begin
      errors++;
      $display("FAIL t5_fire: %0d aes_en pulses required 1", en_cyc.size() - eb);
    end else begin
      checks++;
      if (en_key[eb] !== KEY || en_pt[eb] !== PT) begin
        errors++;
        $display("FAIL t5_values: key %h pt %h required %h %h", en_key[eb], en_pt[eb], KEY, PT);
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef AES_LOADER_BLKCNT_EN
  task automatic test_blkcnt();
    logic [31:0] w[$];
    force dut.blk_cnt_q = 32'hFFFFFFFE;
    @(posedge clk); #1;
    release dut.blk_cnt_q;
    split(PT, w);
    stream(1'b0, w, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if (blk_cnt !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL t6_first: blk_cnt %h required ffffffff", blk_cnt);
    end
    @(posedge clk); #1;
    stream(1'b0, w, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (blk_cnt !== 32'h0) begin
      errors++;
      $display("FAIL t6_wrap: blk_cnt %h required 00000000", blk_cnt);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    s.valid = 1'b0; s.is_key = 1'b0; s.data = '0;
    rst_n = 1'b0; rst3_n = 1'b0;
    test_reset();
    test_pt_before_key();
    test_back_to_back();
    test_key_reload();
    test_reset_wait();
    test_stall();
`ifdef AES_LOADER_BLKCNT_EN
    test_blkcnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
